// File: rtl/decode_queue.sv
// decode_queue: RV32I/M decode stage feeding a DEPTH-entry elastic FIFO.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   flush            synchronous discard of every buffered entry
//   in_valid/ready   fetch handshake; in_instr, in_pc carry the raw instruction
//   out_valid/ready  issue handshake; out_packet, out_pc, out_illegal show the head
//   count            current occupancy
//
// Optional feature: define RV32M_DECODE_EN to decode the RV32M multiply/divide ops.
// Without it, every OP with funct7=0000001 is flagged illegal.

package decode_queue_pkg;

    typedef enum logic [5:0] {
        ALU_OP_NOP,
        ALU_OP_ADD, ALU_OP_SUB, ALU_OP_SLL, ALU_OP_SLT, ALU_OP_SLTU,
        ALU_OP_XOR, ALU_OP_SRL, ALU_OP_SRA, ALU_OP_OR, ALU_OP_AND,
        ALU_OP_ADDI, ALU_OP_SLTI, ALU_OP_SLTIU, ALU_OP_XORI, ALU_OP_ORI,
        ALU_OP_ANDI, ALU_OP_SLLI, ALU_OP_SRLI, ALU_OP_SRAI,
        ALU_OP_LUI, ALU_OP_AUIPC, ALU_OP_JAL, ALU_OP_JALR,
        ALU_OP_BEQ, ALU_OP_BNE, ALU_OP_BLT, ALU_OP_BGE, ALU_OP_BLTU, ALU_OP_BGEU,
        ALU_OP_LB, ALU_OP_LH, ALU_OP_LW, ALU_OP_LBU, ALU_OP_LHU,
        ALU_OP_SB, ALU_OP_SH, ALU_OP_SW,
        ALU_OP_MUL, ALU_OP_MULH, ALU_OP_MULHSU, ALU_OP_MULHU,
        ALU_OP_DIV, ALU_OP_DIVU, ALU_OP_REM, ALU_OP_REMU
    } alu_op_e;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm32;
        alu_op_e     alu_op;
    } rv32_instr_packet_t;

    typedef struct packed {
        rv32_instr_packet_t packet;
        logic [31:0]        pc;
        logic               illegal;
    } dq_entry_t;

endpackage

module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4  // power of two, >= 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_instr,
    input  logic [31:0]                  in_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output rv32_instr_packet_t           out_packet,
    output logic [31:0]                  out_pc,
    output logic                         out_illegal,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] f_rs1, f_rs2, f_rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = in_instr[6:0];
    assign f_rd   = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign f_rs1  = in_instr[19:15];
    assign f_rs2  = in_instr[24:20];
    assign funct7 = in_instr[31:25];

    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};

    rv32_instr_packet_t dec;
    logic               dec_illegal;

    // Combinational decode of the instruction currently offered by fetch.
    always_comb begin
        dec         = '0;
        dec.alu_op  = ALU_OP_NOP;
        dec_illegal = 1'b0;
        case (opcode)
            OPC_LUI:   begin dec.rd = f_rd; dec.imm32 = imm_u; dec.alu_op = ALU_OP_LUI;   end
            OPC_AUIPC: begin dec.rd = f_rd; dec.imm32 = imm_u; dec.alu_op = ALU_OP_AUIPC; end
            OPC_JAL:   begin dec.rd = f_rd; dec.imm32 = imm_j; dec.alu_op = ALU_OP_JAL;   end
            OPC_JALR: begin
                dec.rs1 = f_rs1; dec.rd = f_rd; dec.imm32 = imm_i; dec.alu_op = ALU_OP_JALR;
                dec_illegal = (funct3 != 3'b000);
            end
            OPC_LOAD: begin
                dec.rs1 = f_rs1; dec.rd = f_rd; dec.imm32 = imm_i;
                case (funct3)
                    3'b000:  dec.alu_op = ALU_OP_LB;
                    3'b001:  dec.alu_op = ALU_OP_LH;
                    3'b010:  dec.alu_op = ALU_OP_LW;
                    3'b100:  dec.alu_op = ALU_OP_LBU;
                    3'b101:  dec.alu_op = ALU_OP_LHU;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OPC_STORE: begin
                dec.rs1 = f_rs1; dec.rs2 = f_rs2; dec.imm32 = imm_s;
                case (funct3)
                    3'b000:  dec.alu_op = ALU_OP_SB;
                    3'b001:  dec.alu_op = ALU_OP_SH;
                    3'b010:  dec.alu_op = ALU_OP_SW;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                dec.rs1 = f_rs1; dec.rs2 = f_rs2; dec.imm32 = imm_b;
                case (funct3)
                    3'b000:  dec.alu_op = ALU_OP_BEQ;
                    3'b001:  dec.alu_op = ALU_OP_BNE;
                    3'b100:  dec.alu_op = ALU_OP_BLT;
                    3'b101:  dec.alu_op = ALU_OP_BGE;
                    3'b110:  dec.alu_op = ALU_OP_BLTU;
                    3'b111:  dec.alu_op = ALU_OP_BGEU;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                dec.rs1 = f_rs1; dec.rd = f_rd; dec.imm32 = imm_i;
                case (funct3)
                    3'b000: dec.alu_op = ALU_OP_ADDI;
                    3'b010: dec.alu_op = ALU_OP_SLTI;
                    3'b011: dec.alu_op = ALU_OP_SLTIU;
                    3'b100: dec.alu_op = ALU_OP_XORI;
                    3'b110: dec.alu_op = ALU_OP_ORI;
                    3'b111: dec.alu_op = ALU_OP_ANDI;
                    // Shifts carry only the 5-bit shift amount as immediate.
                    3'b001: begin
                        dec.imm32  = {27'b0, f_rs2};
                        dec.alu_op = ALU_OP_SLLI;
                        dec_illegal = (funct7 != 7'b0000000);
                    end
                    default: begin
                        dec.imm32 = {27'b0, f_rs2};
                        if (funct7 == 7'b0000000)      dec.alu_op = ALU_OP_SRLI;
                        else if (funct7 == 7'b0100000) dec.alu_op = ALU_OP_SRAI;
                        else                           dec_illegal = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                dec.rs1 = f_rs1; dec.rs2 = f_rs2; dec.rd = f_rd;
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: dec.alu_op = ALU_OP_ADD;
                    {7'b0100000, 3'b000}: dec.alu_op = ALU_OP_SUB;
                    {7'b0000000, 3'b001}: dec.alu_op = ALU_OP_SLL;
                    {7'b0000000, 3'b010}: dec.alu_op = ALU_OP_SLT;
                    {7'b0000000, 3'b011}: dec.alu_op = ALU_OP_SLTU;
                    {7'b0000000, 3'b100}: dec.alu_op = ALU_OP_XOR;
                    {7'b0000000, 3'b101}: dec.alu_op = ALU_OP_SRL;
                    {7'b0100000, 3'b101}: dec.alu_op = ALU_OP_SRA;
                    {7'b0000000, 3'b110}: dec.alu_op = ALU_OP_OR;
                    {7'b0000000, 3'b111}: dec.alu_op = ALU_OP_AND;
`ifdef RV32M_DECODE_EN
                    {7'b0000001, 3'b000}: dec.alu_op = ALU_OP_MUL;
                    {7'b0000001, 3'b001}: dec.alu_op = ALU_OP_MULH;
                    {7'b0000001, 3'b010}: dec.alu_op = ALU_OP_MULHSU;
                    {7'b0000001, 3'b011}: dec.alu_op = ALU_OP_MULHU;
                    {7'b0000001, 3'b100}: dec.alu_op = ALU_OP_DIV;
                    {7'b0000001, 3'b101}: dec.alu_op = ALU_OP_DIVU;
                    {7'b0000001, 3'b110}: dec.alu_op = ALU_OP_REM;
                    {7'b0000001, 3'b111}: dec.alu_op = ALU_OP_REMU;
`endif
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
        // Illegal entries are queued as a clean NOP so issue can trap in order.
        if (dec_illegal) begin
            dec        = '0;
            dec.alu_op = ALU_OP_NOP;
        end
    end

    dq_entry_t       mem [DEPTH];
    logic [PW-1:0]   head, tail;
    logic            push, pop;

    assign in_ready  = (count < CW'(DEPTH)) && !flush;
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;

    // Entry storage; occupancy tracking keeps stale slots invisible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= '{packet: dec, pc: in_pc, illegal: dec_illegal};
        end
    end

    // Pointers and occupancy; flush wins over any handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Head view, forced to a zero NOP when the buffer is empty.
    always_comb begin
        out_packet        = '0;
        out_packet.alu_op = ALU_OP_NOP;
        out_pc            = '0;
        out_illegal       = 1'b0;
        if (out_valid) begin
            out_packet  = mem[head].packet;
            out_pc      = mem[head].pc;
            out_illegal = mem[head].illegal;
        end
    end

endmodule

// File: doc/decode_queue.md
# decode_queue

Parameterised, registered decode stage with an elastic output buffer. It accepts raw RV32I/M instructions and their PC from fetch over a valid/ready handshake and decodes each into an `rv32_instr_packet_t`. Decoded entries are held in a DEPTH-entry FIFO and presented to issue over a second valid/ready handshake. Beyond plain decode, it adds illegal-instruction flagging, pipeline flush and occupancy reporting.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- flush  in  1  synchronous discard of all buffered entries
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  buffer can accept this cycle
- in_instr  in  32  raw instruction
- in_pc  in  32  instruction address
- out_valid  out  1  head entry valid
- out_ready  in  1  issue consumes head
- out_packet  out  rv32_instr_packet_t  decoded rs1/rs2/rd/imm32/alu_op
- out_pc  out  32  PC of head entry
- out_illegal  out  1  head entry failed decode
- count  out  $clog2(DEPTH+1)  current occupancy

## Operation
- Decode is combinational on in_instr and is written into the FIFO on accept (`in_valid && in_ready`). A push pushes {packet, pc, illegal}.
- Immediates follow the ISA, sign-extended from instr[31]:
  - I-type: LOAD, JALR, OP_IMM
  - S-type: STORE
  - B-type: BRANCH
  - U-type: LUI, AUIPC
  - J-type: JAL
- Register fields:
  - rs1/rs2/rd populated only when the format uses them; otherwise 0.
  - U-type, JAL: rd only.
  - JALR, LOAD, OP_IMM: rs1, rd.
  - BRANCH, STORE: rs1, rs2.
  - OP: rs1, rs2, rd.
- OP_IMM shifts:
  - SLLI requires instr[31:25]=0000000.
  - funct3=101: instr[31:25]=0000000 → SRLI; 0100000 → SRAI.
  - Any other instr[31:25] → illegal.
- OP: {funct7, funct3} selects the ALU op; M ops are subject to the macro below.
- Illegal (unknown opcode, unsupported funct3/funct7 combination): alu_op=ALU_OP_NOP, register fields and imm32 = 0, illegal=1. An illegal entry is still queued so issue can trap in order.
- FIFO:
  - head/tail pointers of $clog2(DEPTH) bits wrap modulo DEPTH.
  - Pop on `out_valid && out_ready`.
- Output view:
  - out_valid = (count != 0).
  - With out_valid=0, out_packet/out_pc/out_illegal are driven to all-zero with alu_op=ALU_OP_NOP.
- Flush:
  - Clears count and both pointers next edge.
  - in_ready forced 0 while flush=1, so nothing is accepted that cycle.
  - Any pop handshake in the flush cycle is ignored.

## Timing
- Reset values: out_valid=0, in_ready=1, count=0, out_packet zero/NOP, out_pc=0, out_illegal=0, pointers 0.
- Latency: an instruction accepted at edge N is visible on out_* after edge N, i.e. one cycle. There is no bypass from input to output.
- in_ready = (count < DEPTH) && !flush. It is registered-state-derived, with no combinational path from out_ready.
- Full: in_ready=0. A simultaneous pop does not enable a push in the same cycle.
- Empty: no pop possible; a push makes out_valid=1 next cycle.
- Simultaneous push+pop (not full, not empty): count unchanged, both pointers advance.
- rst_n assertion mid-operation: all entries discarded immediately (asynchronous), outputs take reset values without waiting for clk.
- out_* must hold stable while out_valid=1 and out_ready=0.

## Configuration
- RV32M_DECODE_EN defined: OP with funct7=0000001 decodes to MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU by funct3.
- RV32M_DECODE_EN undefined: every OP with funct7=0000001 is illegal (NOP, illegal=1). No M decode logic is present.

## Test plan
- ADDI x1,x0,5 (0x00500093), pc=0x100, out_ready=1 → next cycle:
  - out_valid=1, alu_op=ALU_OP_ADDI, rd=1, rs1=0, imm32=0x00000005, out_pc=0x100, out_illegal=0.
- JALR x0,-4(x1) (0xFFC08067) → alu_op=ALU_OP_JALR, rs1=1, rd=0, imm32=0xFFFFFFFC.
- SRAI x5,x6,3 (0x40335293) → ALU_OP_SRAI, rs1=6, rd=5, imm32[4:0]=3.
- Opcode 0x7F → ALU_OP_NOP, out_illegal=1, still queued.
- MUL x3,x1,x2 (0x022081B3):
  - with macro → ALU_OP_MUL, out_illegal=0.
  - without → ALU_OP_NOP, out_illegal=1.
- DEPTH=4, out_ready=0, push 5 back-to-back:
  - in_ready drops after 4 accepts, count=4.
  - Raise out_ready: entries drain in original PC order.
  - Then a push during a pop in the full cycle is refused.
- Flush and reset:
  - 3 entries buffered, flush=1 with in_valid=1 → no accept, next cycle count=0, out_valid=0.
  - Repeat with rst_n pulsed low mid-stream → immediate reset values.
